// File: rtl/axis_dwidth_adapter.sv
// axis_dwidth_adapter
//   Single-clock AXI4-Stream width converter. C_UPSIZE=1 packs R narrow beats
//   into one wide beat. A TLAST beat flushes a partial wide beat, and its
//   unfilled lanes are zero. C_UPSIZE=0 splits each wide beat into narrow
//   lanes, lane 0 first. When C_DROP_NULL=1, trailing all-zero-strobe lanes of
//   a TLAST beat are not emitted. PKT_CNT counts M-side TLAST handshakes.
// Ports
//   ACLK, ARESETN           clock, async active-low reset
//   S_AXIS_T*               slave stream (narrow when upsizing, wide otherwise)
//   M_AXIS_T*               master stream (wide when upsizing, narrow otherwise)
//   PKT_CNT                 completed packets on the M side (wraps)
module axis_dwidth_adapter #(
  parameter int C_NARROW_TDATA_WIDTH = 64,
  parameter int C_RATIO              = 2,
  parameter int C_UPSIZE             = 1,
  parameter int C_NARROW_TUSER_WIDTH = 22,
  parameter int C_DROP_NULL          = 1,
  localparam int N  = C_NARROW_TDATA_WIDTH,
  localparam int R  = C_RATIO,
  localparam int U  = C_NARROW_TUSER_WIDTH,
  localparam int W  = N * R,
  localparam int NB = N / 8,
  localparam int SW = (C_UPSIZE != 0) ? N : W,
  localparam int MW = (C_UPSIZE != 0) ? W : N,
  localparam int SU = (C_UPSIZE != 0) ? U : U * R,
  localparam int MU = (C_UPSIZE != 0) ? U * R : U
) (
  input  logic          ACLK,
  input  logic          ARESETN,
  input  logic          S_AXIS_TVALID,
  output logic          S_AXIS_TREADY,
  input  logic [SW-1:0] S_AXIS_TDATA,
  input  logic [SW/8-1:0] S_AXIS_TSTRB,
  input  logic          S_AXIS_TLAST,
  input  logic [SU-1:0] S_AXIS_TUSER,
  output logic          M_AXIS_TVALID,
  input  logic          M_AXIS_TREADY,
  output logic [MW-1:0] M_AXIS_TDATA,
  output logic [MW/8-1:0] M_AXIS_TSTRB,
  output logic          M_AXIS_TLAST,
  output logic [MU-1:0] M_AXIS_TUSER,
  output logic [31:0]   PKT_CNT
);

  localparam int IW = (R > 1) ? $clog2(R) : 1;

  logic        rdy_en;
  logic        m_valid;
  logic        m_last;
  logic        m_hs;
  logic [31:0] pkt_cnt_q;

  assign m_hs          = m_valid & M_AXIS_TREADY;
  assign M_AXIS_TVALID = m_valid;
  assign M_AXIS_TLAST  = m_last;
  assign PKT_CNT       = pkt_cnt_q;

  // rdy_en keeps S_AXIS_TREADY low until the first edge after reset release
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdy_en    <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (m_hs && m_last) pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  if (C_UPSIZE != 0) begin : g_up
    logic [IW-1:0]  idx;
    logic [W-1:0]   acc_data, mrg_data, out_data;
    logic [W/8-1:0] acc_strb, mrg_strb, out_strb;
    logic [U*R-1:0] acc_user, mrg_user, out_user;
    logic           out_valid, out_last, s_ready, s_hs, done;

    assign s_ready = rdy_en & (~out_valid | M_AXIS_TREADY);
    assign s_hs    = S_AXIS_TVALID & s_ready;
    assign done    = (idx == IW'(R - 1)) | S_AXIS_TLAST;

    // The accumulator is zeroed after every completed beat, so lanes above
    // idx are already zero when a TLAST flush happens.
    always_comb begin
      mrg_data = acc_data;
      mrg_strb = acc_strb;
      mrg_user = acc_user;
      for (int k = 0; k < R; k++) begin
        if (idx == IW'(k)) begin
          mrg_data[k*N +: N]   = S_AXIS_TDATA;
          mrg_strb[k*NB +: NB] = S_AXIS_TSTRB;
          mrg_user[k*U +: U]   = S_AXIS_TUSER;
        end
      end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
        idx       <= '0;
        acc_data  <= '0;
        acc_strb  <= '0;
        acc_user  <= '0;
        out_data  <= '0;
        out_strb  <= '0;
        out_user  <= '0;
        out_last  <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        if (m_hs) out_valid <= 1'b0;
        if (s_hs) begin
          if (done) begin
            out_data  <= mrg_data;
            out_strb  <= mrg_strb;
            out_user  <= mrg_user;
            out_last  <= S_AXIS_TLAST;
            out_valid <= 1'b1;
            acc_data  <= '0;
            acc_strb  <= '0;
            acc_user  <= '0;
            idx       <= '0;
          end else begin
            acc_data <= mrg_data;
            acc_strb <= mrg_strb;
            acc_user <= mrg_user;
            idx      <= idx + 1'b1;
          end
        end
      end
    end

    assign S_AXIS_TREADY = s_ready;
    assign M_AXIS_TDATA  = out_data;
    assign M_AXIS_TSTRB  = out_strb;
    assign M_AXIS_TUSER  = out_user;
    assign m_valid       = out_valid;
    assign m_last        = out_last;
  end else begin : g_down
    logic [IW-1:0]  idx;
    logic [W-1:0]   hold_data;
    logic [W/8-1:0] hold_strb;
    logic [U*R-1:0] hold_user;
    logic           hold_last, hold_valid;
    logic [N-1:0]   lane_data;
    logic [NB-1:0]  lane_strb;
    logic [U-1:0]   lane_user;
    logic           upper_null, lane_last, s_ready, s_hs;

    // upper_null: every lane above the current one has an all-zero strobe
    always_comb begin
      lane_data  = '0;
      lane_strb  = '0;
      lane_user  = '0;
      upper_null = 1'b1;
      for (int k = 0; k < R; k++) begin
        if (idx == IW'(k)) begin
          lane_data = hold_data[k*N +: N];
          lane_strb = hold_strb[k*NB +: NB];
          lane_user = hold_user[k*U +: U];
        end
        if ((IW'(k) > idx) && (hold_strb[k*NB +: NB] != '0)) upper_null = 1'b0;
      end
    end

    assign lane_last = (idx == IW'(R - 1)) |
                       ((C_DROP_NULL != 0) & hold_last & upper_null);
    // A new wide beat is taken in the same cycle as the final lane drains.
    assign s_ready   = rdy_en & (~hold_valid | (M_AXIS_TREADY & lane_last));
    assign s_hs      = S_AXIS_TVALID & s_ready;

    always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
        idx        <= '0;
        hold_data  <= '0;
        hold_strb  <= '0;
        hold_user  <= '0;
        hold_last  <= 1'b0;
        hold_valid <= 1'b0;
      end else if (s_hs) begin
        hold_data  <= S_AXIS_TDATA;
        hold_strb  <= S_AXIS_TSTRB;
        hold_user  <= S_AXIS_TUSER;
        hold_last  <= S_AXIS_TLAST;
        hold_valid <= 1'b1;
        idx        <= '0;
      end else if (m_hs) begin
        if (lane_last) begin
          hold_valid <= 1'b0;
          idx        <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end

    assign S_AXIS_TREADY = s_ready;
    assign M_AXIS_TDATA  = lane_data;
    assign M_AXIS_TSTRB  = lane_strb;
    assign M_AXIS_TUSER  = lane_user;
    assign m_valid       = hold_valid;
    assign m_last        = hold_last & lane_last;
  end

endmodule

// File: tb/tb_axis_dwidth_adapter.sv
// Testbench for axis_dwidth_adapter: two upsizer instances (R=2, R=4) and two
// R=2 downsizer instances (null-lane dropping on and off). Directed scenarios
// plus randomised backpressure with a small reference model.
module tb_axis_dwidth_adapter;

  typedef struct packed {logic [63:0] d; logic [7:0] s; logic [21:0] u; logic l;} nb_t;
  typedef struct packed {logic [127:0] d; logic [15:0] s; logic [43:0] u; logic l;} w2_t;
  typedef struct packed {logic [255:0] d; logic [31:0] s; logic [87:0] u; logic l;} w4_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // upsize R=2
  logic u2_s_valid = 0, u2_s_ready, u2_s_last = 0;
  logic [63:0] u2_s_data = '0; logic [7:0] u2_s_strb = '0; logic [21:0] u2_s_user = '0;
  logic u2_m_valid, u2_m_ready = 1, u2_m_last;
  logic [127:0] u2_m_data; logic [15:0] u2_m_strb; logic [43:0] u2_m_user;
  logic [31:0] u2_cnt;
  // upsize R=4
  logic u4_s_valid = 0, u4_s_ready, u4_s_last = 0;
  logic [63:0] u4_s_data = '0; logic [7:0] u4_s_strb = '0; logic [21:0] u4_s_user = '0;
  logic u4_m_valid, u4_m_ready = 1, u4_m_last;
  logic [255:0] u4_m_data; logic [31:0] u4_m_strb; logic [87:0] u4_m_user;
  logic [31:0] u4_cnt;
  // downsize R=2, drop null lanes
  logic d1_s_valid = 0, d1_s_ready, d1_s_last = 0;
  logic [127:0] d1_s_data = '0; logic [15:0] d1_s_strb = '0; logic [43:0] d1_s_user = '0;
  logic d1_m_valid, d1_m_ready = 1, d1_m_last;
  logic [63:0] d1_m_data; logic [7:0] d1_m_strb; logic [21:0] d1_m_user;
  logic [31:0] d1_cnt;
  // downsize R=2, keep null lanes
  logic d0_s_valid = 0, d0_s_ready, d0_s_last = 0;
  logic [127:0] d0_s_data = '0; logic [15:0] d0_s_strb = '0; logic [43:0] d0_s_user = '0;
  logic d0_m_valid, d0_m_ready = 1, d0_m_last;
  logic [63:0] d0_m_data; logic [7:0] d0_m_strb; logic [21:0] d0_m_user;
  logic [31:0] d0_cnt;

  axis_dwidth_adapter #(.C_NARROW_TDATA_WIDTH(64), .C_RATIO(2), .C_UPSIZE(1),
                        .C_NARROW_TUSER_WIDTH(22), .C_DROP_NULL(1)) u2_dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXIS_TVALID(u2_s_valid), .S_AXIS_TREADY(u2_s_ready), .S_AXIS_TDATA(u2_s_data),
    .S_AXIS_TSTRB(u2_s_strb), .S_AXIS_TLAST(u2_s_last), .S_AXIS_TUSER(u2_s_user),
    .M_AXIS_TVALID(u2_m_valid), .M_AXIS_TREADY(u2_m_ready), .M_AXIS_TDATA(u2_m_data),
    .M_AXIS_TSTRB(u2_m_strb), .M_AXIS_TLAST(u2_m_last), .M_AXIS_TUSER(u2_m_user),
    .PKT_CNT(u2_cnt));

  axis_dwidth_adapter #(.C_NARROW_TDATA_WIDTH(64), .C_RATIO(4), .C_UPSIZE(1),
                        .C_NARROW_TUSER_WIDTH(22), .C_DROP_NULL(1)) u4_dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXIS_TVALID(u4_s_valid), .S_AXIS_TREADY(u4_s_ready), .S_AXIS_TDATA(u4_s_data),
    .S_AXIS_TSTRB(u4_s_strb), .S_AXIS_TLAST(u4_s_last), .S_AXIS_TUSER(u4_s_user),
    .M_AXIS_TVALID(u4_m_valid), .M_AXIS_TREADY(u4_m_ready), .M_AXIS_TDATA(u4_m_data),
    .M_AXIS_TSTRB(u4_m_strb), .M_AXIS_TLAST(u4_m_last), .M_AXIS_TUSER(u4_m_user),
    .PKT_CNT(u4_cnt));

  axis_dwidth_adapter #(.C_NARROW_TDATA_WIDTH(64), .C_RATIO(2), .C_UPSIZE(0),
                        .C_NARROW_TUSER_WIDTH(22), .C_DROP_NULL(1)) d1_dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXIS_TVALID(d1_s_valid), .S_AXIS_TREADY(d1_s_ready), .S_AXIS_TDATA(d1_s_data),
    .S_AXIS_TSTRB(d1_s_strb), .S_AXIS_TLAST(d1_s_last), .S_AXIS_TUSER(d1_s_user),
    .M_AXIS_TVALID(d1_m_valid), .M_AXIS_TREADY(d1_m_ready), .M_AXIS_TDATA(d1_m_data),
    .M_AXIS_TSTRB(d1_m_strb), .M_AXIS_TLAST(d1_m_last), .M_AXIS_TUSER(d1_m_user),
    .PKT_CNT(d1_cnt));

  axis_dwidth_adapter #(.C_NARROW_TDATA_WIDTH(64), .C_RATIO(2), .C_UPSIZE(0),
                        .C_NARROW_TUSER_WIDTH(22), .C_DROP_NULL(0)) d0_dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXIS_TVALID(d0_s_valid), .S_AXIS_TREADY(d0_s_ready), .S_AXIS_TDATA(d0_s_data),
    .S_AXIS_TSTRB(d0_s_strb), .S_AXIS_TLAST(d0_s_last), .S_AXIS_TUSER(d0_s_user),
    .M_AXIS_TVALID(d0_m_valid), .M_AXIS_TREADY(d0_m_ready), .M_AXIS_TDATA(d0_m_data),
    .M_AXIS_TSTRB(d0_m_strb), .M_AXIS_TLAST(d0_m_last), .M_AXIS_TUSER(d0_m_user),
    .PKT_CNT(d0_cnt));

  // Output collectors: inputs change only at posedge+1, so the negedge sample
  // shows exactly what the next rising edge will hand over.
  w2_t u2_q[$];
  w4_t u4_q[$];
  nb_t d1_q[$];
  nb_t d0_q[$];
  int  d0_ts[$];
  always @(negedge clk) begin
    if (u2_m_valid && u2_m_ready) u2_q.push_back({u2_m_data, u2_m_strb, u2_m_user, u2_m_last});
    if (u4_m_valid && u4_m_ready) u4_q.push_back({u4_m_data, u4_m_strb, u4_m_user, u4_m_last});
    if (d1_m_valid && d1_m_ready) d1_q.push_back({d1_m_data, d1_m_strb, d1_m_user, d1_m_last});
    if (d0_m_valid && d0_m_ready) begin
      d0_q.push_back({d0_m_data, d0_m_strb, d0_m_user, d0_m_last});
      d0_ts.push_back(cyc);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Send tasks start and end at posedge+1.
  task automatic u2_send(input nb_t b);
    int n = 0;
    u2_s_valid = 1'b1;
    {u2_s_data, u2_s_strb, u2_s_user, u2_s_last} = b;
    forever begin
      @(negedge clk);
      if (u2_s_ready) break;
      n++;
      if (n > 200) begin checks++; errors++; $display("FAIL u2_send timeout waited %0d required <=200", n); break; end
    end
    @(posedge clk); #1;
    u2_s_valid = 1'b0;
  endtask

  task automatic u4_send(input nb_t b);
    int n = 0;
    u4_s_valid = 1'b1;
    {u4_s_data, u4_s_strb, u4_s_user, u4_s_last} = b;
    forever begin
      @(negedge clk);
      if (u4_s_ready) break;
      n++;
      if (n > 200) begin checks++; errors++; $display("FAIL u4_send timeout waited %0d required <=200", n); break; end
    end
    @(posedge clk); #1;
    u4_s_valid = 1'b0;
  endtask

  task automatic d1_send(input w2_t b);
    int n = 0;
    d1_s_valid = 1'b1;
    {d1_s_data, d1_s_strb, d1_s_user, d1_s_last} = b;
    forever begin
      @(negedge clk);
      if (d1_s_ready) break;
      n++;
      if (n > 200) begin checks++; errors++; $display("FAIL d1_send timeout waited %0d required <=200", n); break; end
    end
    @(posedge clk); #1;
    d1_s_valid = 1'b0;
  endtask

  task automatic d0_send(input w2_t b);
    int n = 0;
    d0_s_valid = 1'b1;
    {d0_s_data, d0_s_strb, d0_s_user, d0_s_last} = b;
    forever begin
      @(negedge clk);
      if (d0_s_ready) break;
      n++;
      if (n > 200) begin checks++; errors++; $display("FAIL d0_send timeout waited %0d required <=200", n); break; end
    end
    @(posedge clk); #1;
    d0_s_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (u2_m_valid !== 1'b0) begin errors++; $display("FAIL reset_u2_mvalid got %b exp 0", u2_m_valid); end
    checks++; if (u2_s_ready !== 1'b0) begin errors++; $display("FAIL reset_u2_sready got %b exp 0", u2_s_ready); end
    checks++; if (d1_m_valid !== 1'b0) begin errors++; $display("FAIL reset_d1_mvalid got %b exp 0", d1_m_valid); end
    checks++; if (d1_s_ready !== 1'b0) begin errors++; $display("FAIL reset_d1_sready got %b exp 0", d1_s_ready); end
    checks++; if (u2_cnt !== 32'd0) begin errors++; $display("FAIL reset_pkt_cnt got %h exp 0", u2_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (u2_s_ready !== 1'b0) begin errors++; $display("FAIL rdy_en_delay got %b exp 0", u2_s_ready); end
    @(posedge clk); #1;
    checks++; if (u2_s_ready !== 1'b1) begin errors++; $display("FAIL rdy_en_set_u2 got %b exp 1", u2_s_ready); end
    checks++; if (d1_s_ready !== 1'b1) begin errors++; $display("FAIL rdy_en_set_d1 got %b exp 1", d1_s_ready); end
  endtask

  task automatic test_upsize_r2();
    w2_t e0, e1;
    int t0;
    u2_q.delete();
    u2_m_ready = 1'b1;
    t0 = cyc;
    u2_send({64'h1111_1111_1111_1111, 8'hFF, 22'h000011, 1'b0});
    u2_send({64'h2222_2222_2222_2222, 8'hFF, 22'h000022, 1'b0});
    u2_send({64'h3333_3333_3333_3333, 8'hFF, 22'h000033, 1'b0});
    u2_send({64'h4444_4444_4444_4444, 8'hFF, 22'h000044, 1'b1});
    checks++; if (cyc - t0 !== 4) begin errors++; $display("FAIL up2_sustained cycles got %0d exp 4", cyc - t0); end
    checks++; if (u2_m_valid !== 1'b1) begin errors++; $display("FAIL up2_latency mvalid got %b exp 1", u2_m_valid); end
    idle(2);
    e0 = {128'h2222_2222_2222_2222_1111_1111_1111_1111, 16'hFFFF, {22'h000022, 22'h000011}, 1'b0};
    e1 = {128'h4444_4444_4444_4444_3333_3333_3333_3333, 16'hFFFF, {22'h000044, 22'h000033}, 1'b1};
    checks++;
    if (u2_q.size() !== 2) begin errors++; $display("FAIL up2_count got %0d exp 2", u2_q.size()); end
    else begin
      checks++; if (u2_q[0] !== e0) begin errors++; $display("FAIL up2_beat0 got %h exp %h", u2_q[0], e0); end
      checks++; if (u2_q[1] !== e1) begin errors++; $display("FAIL up2_beat1 got %h exp %h", u2_q[1], e1); end
    end
    checks++; if (u2_cnt !== 32'd1) begin errors++; $display("FAIL up2_pkt_cnt got %0d exp 1", u2_cnt); end
  endtask

  task automatic test_upsize_r4_flush();
    w4_t e0, e1;
    u4_q.delete();
    u4_m_ready = 1'b1;
    u4_send({64'hA0A0_A0A0_A0A0_A0A0, 8'hFF, 22'h0000A1, 1'b0});
    u4_send({64'hB0B0_B0B0_B0B0_B0B0, 8'hFF, 22'h0000B1, 1'b0});
    u4_send({64'hC0C0_C0C0_C0C0_C0C0, 8'hFF, 22'h0000C1, 1'b1});
    checks++; if (u4_m_valid !== 1'b1) begin errors++; $display("FAIL up4_latency mvalid got %b exp 1", u4_m_valid); end
    u4_send({64'hD0D0_D0D0_D0D0_D0D0, 8'h0F, 22'h0000D1, 1'b1});
    idle(2);
    e0 = '0;
    e0.d[191:0] = {64'hC0C0_C0C0_C0C0_C0C0, 64'hB0B0_B0B0_B0B0_B0B0, 64'hA0A0_A0A0_A0A0_A0A0};
    e0.s = 32'h00FF_FFFF;
    e0.u[65:0] = {22'h0000C1, 22'h0000B1, 22'h0000A1};
    e0.l = 1'b1;
    e1 = '0;
    e1.d[63:0] = 64'hD0D0_D0D0_D0D0_D0D0;
    e1.s = 32'h0000_000F;
    e1.u[21:0] = 22'h0000D1;
    e1.l = 1'b1;
    checks++;
    if (u4_q.size() !== 2) begin errors++; $display("FAIL up4_count got %0d exp 2", u4_q.size()); end
    else begin
      checks++; if (u4_q[0] !== e0) begin errors++; $display("FAIL up4_flush3 got %h exp %h", u4_q[0], e0); end
      checks++; if (u4_q[1] !== e1) begin errors++; $display("FAIL up4_flush1 got %h exp %h", u4_q[1], e1); end
    end
    checks++; if (u4_cnt !== 32'd2) begin errors++; $display("FAIL up4_pkt_cnt got %0d exp 2", u4_cnt); end
  endtask

  task automatic test_downsize_null();
    nb_t e[$];
    d1_q.delete(); d0_q.delete(); d0_ts.delete();
    d1_m_ready = 1'b1; d0_m_ready = 1'b1;
    d1_send({64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001, 16'h00FF, {22'h000052, 22'h000051}, 1'b1});
    checks++; if (d1_m_valid !== 1'b1) begin errors++; $display("FAIL dn_latency mvalid got %b exp 1", d1_m_valid); end
    d0_send({64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001, 16'h00FF, {22'h000052, 22'h000051}, 1'b1});
    idle(3);
    checks++;
    if (d1_q.size() !== 1) begin errors++; $display("FAIL dn_drop_count got %0d exp 1", d1_q.size()); end
    else begin
      checks++;
      if (d1_q[0] !== nb_t'({64'h5555_0000_0000_0001, 8'hFF, 22'h000051, 1'b1})) begin
        errors++; $display("FAIL dn_drop_beat got %h", d1_q[0]);
      end
    end
    e = '{nb_t'({64'h5555_0000_0000_0001, 8'hFF, 22'h000051, 1'b0}),
          nb_t'({64'h5555_0000_0000_0002, 8'h00, 22'h000052, 1'b1})};
    checks++;
    if (d0_q.size() !== 2) begin errors++; $display("FAIL dn_keep_count got %0d exp 2", d0_q.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        checks++; if (d0_q[i] !== e[i]) begin errors++; $display("FAIL dn_keep_beat%0d got %h exp %h", i, d0_q[i], e[i]); end
      end
    end
    // null upper lane without TLAST is still emitted; all-null TLAST beat still emits lane 0
    d1_q.delete();
    d1_send({64'h6666_0000_0000_0002, 64'h6666_0000_0000_0001, 16'h00FF, {22'h000062, 22'h000061}, 1'b0});
    d1_send({64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001, 16'h0000, {22'h000072, 22'h000071}, 1'b1});
    idle(3);
    e = '{nb_t'({64'h6666_0000_0000_0001, 8'hFF, 22'h000061, 1'b0}),
          nb_t'({64'h6666_0000_0000_0002, 8'h00, 22'h000062, 1'b0}),
          nb_t'({64'h7777_0000_0000_0001, 8'h00, 22'h000071, 1'b1})};
    checks++;
    if (d1_q.size() !== 3) begin errors++; $display("FAIL dn_nolast_count got %0d exp 3", d1_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (d1_q[i] !== e[i]) begin errors++; $display("FAIL dn_nolast_beat%0d got %h exp %h", i, d1_q[i], e[i]); end
      end
    end
    checks++; if (d1_cnt !== 32'd2) begin errors++; $display("FAIL dn_pkt_cnt got %0d exp 2", d1_cnt); end
    checks++; if (d0_cnt !== 32'd1) begin errors++; $display("FAIL dn0_pkt_cnt got %0d exp 1", d0_cnt); end
  endtask

  task automatic test_back_to_back();
    nb_t e[$];
    w2_t w;
    d0_q.delete(); d0_ts.delete();
    d0_m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      w.d = {64'hB2B0_0000_0000_0000 | 64'(2*k + 1), 64'hB2B0_0000_0000_0000 | 64'(2*k)};
      w.s = 16'hFFFF;
      w.u = {22'(16 + 2*k + 1), 22'(16 + 2*k)};
      w.l = (k == 2);
      e.push_back({w.d[63:0], 8'hFF, w.u[21:0], 1'b0});
      e.push_back({w.d[127:64], 8'hFF, w.u[43:22], w.l});
      d0_send(w);
    end
    idle(3);
    checks++;
    if (d0_q.size() !== 6) begin errors++; $display("FAIL b2b_count got %0d exp 6", d0_q.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (d0_q[i] !== e[i]) begin errors++; $display("FAIL b2b_beat%0d got %h exp %h", i, d0_q[i], e[i]); end
        checks++; if (d0_ts[i] - d0_ts[0] !== i) begin errors++; $display("FAIL b2b_gap%0d got %0d exp %0d", i, d0_ts[i] - d0_ts[0], i); end
      end
    end
  endtask

  task automatic test_backpressure_up();
    nb_t stim[$];
    w2_t exp_q[$];
    w2_t e, cur, prev;
    logic pv, pr;
    int n, len, li;
    nb_t b;
    u2_q.delete();
    li = 0; e = '0;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 5);
      for (int j = 0; j < len; j++) begin
        b.d = {$urandom, $urandom}; b.s = 8'($urandom); b.u = 22'($urandom); b.l = (j == len - 1);
        stim.push_back(b);
        if (li == 0) begin
          e = '0; e.d[63:0] = b.d; e.s[7:0] = b.s; e.u[21:0] = b.u; e.l = b.l;
          if (b.l) exp_q.push_back(e); else li = 1;
        end else begin
          e.d[127:64] = b.d; e.s[15:8] = b.s; e.u[43:22] = b.u; e.l = b.l;
          exp_q.push_back(e); li = 0;
        end
      end
    end
    pv = 1'b0; pr = 1'b0; prev = '0; n = 0;
    fork
      begin
        foreach (stim[i]) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          u2_send(stim[i]);
        end
      end
      begin
        while (u2_q.size() < exp_q.size() && n < 8000) begin
          @(negedge clk);
          cur = {u2_m_data, u2_m_strb, u2_m_user, u2_m_last};
          if (pv && !pr) begin
            checks++;
            if (u2_m_valid !== 1'b1 || cur !== prev) begin
              errors++; $display("FAIL up_stall_stable got v=%b %h exp v=1 %h", u2_m_valid, cur, prev);
            end
          end
          pv = u2_m_valid; pr = u2_m_ready; prev = cur;
          @(posedge clk); #1;
          u2_m_ready = ($urandom_range(0, 9) < 3);
          n++;
        end
      end
    join
    u2_m_ready = 1'b1;
    idle(2);
    checks++;
    if (u2_q.size() !== exp_q.size()) begin errors++; $display("FAIL up_bp_count got %0d exp %0d", u2_q.size(), exp_q.size()); end
    else begin
      foreach (exp_q[i]) begin
        checks++; if (u2_q[i] !== exp_q[i]) begin errors++; $display("FAIL up_bp_beat%0d got %h exp %h", i, u2_q[i], exp_q[i]); end
      end
    end
    checks++; if (u2_cnt !== 32'd41) begin errors++; $display("FAIL up_bp_pkt_cnt got %0d exp 41", u2_cnt); end
  endtask

  task automatic test_backpressure_down();
    w2_t stim[$];
    nb_t exp_q[$];
    nb_t cur, prev;
    logic pv, pr, drop;
    int n, len;
    w2_t b;
    d1_q.delete();
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 3);
      for (int j = 0; j < len; j++) begin
        b.d = {$urandom, $urandom, $urandom, $urandom};
        b.u = {12'($urandom), $urandom};
        b.l = (j == len - 1);
        if (b.l) b.s = {($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom), 8'($urandom)};
        else     b.s = 16'($urandom);
        stim.push_back(b);
        drop = b.l && (b.s[15:8] == 8'h00);
        exp_q.push_back({b.d[63:0], b.s[7:0], b.u[21:0], drop});
        if (!drop) exp_q.push_back({b.d[127:64], b.s[15:8], b.u[43:22], b.l});
      end
    end
    pv = 1'b0; pr = 1'b0; prev = '0; n = 0;
    fork
      begin
        foreach (stim[i]) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          d1_send(stim[i]);
        end
      end
      begin
        while (d1_q.size() < exp_q.size() && n < 8000) begin
          @(negedge clk);
          cur = {d1_m_data, d1_m_strb, d1_m_user, d1_m_last};
          if (pv && !pr) begin
            checks++;
            if (d1_m_valid !== 1'b1 || cur !== prev) begin
              errors++; $display("FAIL dn_stall_stable got v=%b %h exp v=1 %h", d1_m_valid, cur, prev);
            end
          end
          pv = d1_m_valid; pr = d1_m_ready; prev = cur;
          @(posedge clk); #1;
          d1_m_ready = ($urandom_range(0, 9) < 3);
          n++;
        end
      end
    join
    d1_m_ready = 1'b1;
    idle(2);
    checks++;
    if (d1_q.size() !== exp_q.size()) begin errors++; $display("FAIL dn_bp_count got %0d exp %0d", d1_q.size(), exp_q.size()); end
    else begin
      foreach (exp_q[i]) begin
        checks++; if (d1_q[i] !== exp_q[i]) begin errors++; $display("FAIL dn_bp_beat%0d got %h exp %h", i, d1_q[i], exp_q[i]); end
      end
    end
    checks++; if (d1_cnt !== 32'd42) begin errors++; $display("FAIL dn_bp_pkt_cnt got %0d exp 42", d1_cnt); end
  endtask

  task automatic test_reset_mid_packet();
    nb_t e0, e1;
    w2_t ew;
    u2_q.delete(); d1_q.delete();
    u2_m_ready = 1'b1;
    u2_send({64'hDEAD_DEAD_DEAD_DEAD, 8'hFF, 22'h0000EE, 1'b0});
    d1_m_ready = 1'b0;
    d1_send({64'h8888_0000_0000_0002, 64'h8888_0000_0000_0001, 16'hFFFF, {22'h000082, 22'h000081}, 1'b1});
    d1_m_ready = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    d1_m_ready = 1'b0;
    checks++; if (d1_m_valid !== 1'b1) begin errors++; $display("FAIL rstmid_lane1_pending got %b exp 1", d1_m_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (d1_m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_mvalid got %b exp 0", d1_m_valid); end
    checks++; if (d1_s_ready !== 1'b0) begin errors++; $display("FAIL rstmid_sready got %b exp 0", d1_s_ready); end
    checks++; if (d1_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_pkt_cnt got %0d exp 0", d1_cnt); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (d1_s_ready !== 1'b0) begin errors++; $display("FAIL rstmid_sready_release got %b exp 0", d1_s_ready); end
    @(posedge clk); #1;
    checks++; if (d1_s_ready !== 1'b1) begin errors++; $display("FAIL rstmid_sready_after got %b exp 1", d1_s_ready); end
    u2_q.delete(); d1_q.delete();
    d1_m_ready = 1'b1;
    d1_send({64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001, 16'hFFFF, {22'h000092, 22'h000091}, 1'b1});
    u2_send({64'h1234_5678_0000_0001, 8'hFF, 22'h000101, 1'b0});
    u2_send({64'h1234_5678_0000_0002, 8'h3C, 22'h000102, 1'b1});
    idle(3);
    e0 = {64'h9999_0000_0000_0001, 8'hFF, 22'h000091, 1'b0};
    e1 = {64'h9999_0000_0000_0002, 8'hFF, 22'h000092, 1'b1};
    checks++;
    if (d1_q.size() !== 2) begin errors++; $display("FAIL rstmid_dn_count got %0d exp 2", d1_q.size()); end
    else begin
      checks++; if (d1_q[0] !== e0) begin errors++; $display("FAIL rstmid_dn_beat0 got %h exp %h", d1_q[0], e0); end
      checks++; if (d1_q[1] !== e1) begin errors++; $display("FAIL rstmid_dn_beat1 got %h exp %h", d1_q[1], e1); end
    end
    ew = {128'h1234_5678_0000_0002_1234_5678_0000_0001, 16'h3CFF, {22'h000102, 22'h000101}, 1'b1};
    checks++;
    if (u2_q.size() !== 1) begin errors++; $display("FAIL rstmid_up_count got %0d exp 1", u2_q.size()); end
    else begin
      checks++; if (u2_q[0] !== ew) begin errors++; $display("FAIL rstmid_up_beat got %h exp %h", u2_q[0], ew); end
    end
  endtask

  task automatic test_pkt_cnt_wrap();
    force u2_dut.pkt_cnt_q = 32'hFFFF_FFFF;
    #1;
    release u2_dut.pkt_cnt_q;
    checks++; if (u2_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload got %h exp ffffffff", u2_cnt); end
    @(posedge clk); #1;
    u2_m_ready = 1'b1;
    u2_send({64'h0F0F_0F0F_0F0F_0F0F, 8'hFF, 22'h000F0F, 1'b1});
    idle(2);
    checks++; if (u2_cnt !== 32'd0) begin errors++; $display("FAIL wrap_pkt_cnt got %h exp 0", u2_cnt); end
  endtask

  initial begin
    test_reset();
    test_upsize_r2();
    test_upsize_r4_flush();
    test_downsize_null();
    test_back_to_back();
    test_backpressure_up();
    test_backpressure_down();
    test_reset_mid_packet();
    test_pkt_cnt_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached limit required finish earlier");
    $fatal(1, "timeout");
  end

endmodule
